// File: rtl/mips_dbg_pkg.sv
// Shared encodings and default constants for the MIPS step/run sequencer.
package mips_dbg_pkg;

  localparam int unsigned ST_W                = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_RUN_DIV         = 25000000;
  localparam int unsigned DEF_CNT_W           = 32;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_RUN    = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/key_debounce.sv
// Key synchronizer and debouncer: emits a one-cycle press pulse when an
// active-low key has been stably low for DEBOUNCE_CYCLES cycles.
module key_debounce
  import mips_dbg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          press_q, press_d;

  // Two-flop synchronizer; idles at the released level.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive cycles that disagree with the accepted level.
  always_comb begin
    acc_d   = acc_q;
    cnt_d   = '0;
    press_d = 1'b0;
    cnt_inc = cnt_q + CW'(1);
    if (sync2_q != acc_q) begin
      if (cnt_inc == CW'(DEBOUNCE_CYCLES)) begin
        acc_d   = sync2_q;
        press_d = ~sync2_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/mips_step_ctrl.sv
// Clock-enable sequencer for the MIPS core: debounced single-step, slow
// free-running RUN mode, halt handling and a cpu_en pulse counter.
// Optional breakpoint support is built when MIPS_BREAK_EN is defined.
module mips_step_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned RUN_DIV         = DEF_RUN_DIV,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step_n,
  input  logic             run_sw,
  input  logic             halt,
`ifdef MIPS_BREAK_EN
  input  logic [31:0]      pc,
  input  logic [31:0]      bp_addr,
  input  logic             bp_valid,
`endif
  output logic             cpu_en,
  output logic             latch,
  output logic [CNT_W-1:0] cycle_count,
  output logic [ST_W-1:0]  state
);

  localparam int unsigned DIV_W = $clog2(RUN_DIV);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               cpu_en_q, cpu_en_d;
  logic               latch_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               press;
  logic               bp_hit_c;
  logic               stop_c;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clock (clock),
    .reset (reset),
    .key_n (step_n),
    .press (press)
  );

  // Breakpoint match is only meaningful on a cycle where a pulse is issued.
`ifdef MIPS_BREAK_EN
  assign bp_hit_c = cpu_en_q & bp_valid & (pc == bp_addr);
`else
  assign bp_hit_c = 1'b0;
`endif

  assign stop_c = halt | bp_hit_c;

  // Next-state, run divider and pulse generation; halt wins over any pulse.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    cpu_en_d = 1'b0;
    cnt_d    = cnt_q + CNT_W'(cpu_en_q);
    unique case (state_q)
      ST_IDLE: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (run_sw) begin
          state_d = ST_RUN;
        end else if (press) begin
          state_d  = ST_STEP;
          cpu_en_d = 1'b1;
        end
      end
      ST_STEP: begin
        state_d = stop_c ? ST_HALTED : ST_IDLE;
      end
      ST_RUN: begin
        if (stop_c) begin
          state_d = ST_HALTED;
          div_d   = '0;
        end else if (!run_sw) begin
          state_d = ST_IDLE;
          div_d   = '0;
        end else if (div_q == DIV_W'(RUN_DIV - 1)) begin
          div_d    = '0;
          cpu_en_d = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      cpu_en_q <= 1'b0;
      latch_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      cpu_en_q <= cpu_en_d;
      latch_q  <= cpu_en_q;
      cnt_q    <= cnt_d;
    end
  end

  assign cpu_en      = cpu_en_q;
  assign latch       = latch_q;
  assign cycle_count = cnt_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_step_ctrl.sv
// Bench for mips_step_ctrl: directed scenarios plus random stimulus checked
// every cycle against a window-based behavioural model.
module tb_mips_step_ctrl;

  localparam int unsigned DB  = 4;
  localparam int unsigned DIV = 5;
  localparam int unsigned CW  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          step_n = 1'b1;
  logic          run_sw = 1'b0;
  logic          halt = 1'b0;
  logic          cpu_en, latch;
  logic [CW-1:0] cycle_count;
  logic [1:0]    state;
`ifdef MIPS_BREAK_EN
  logic [31:0]   pc = '0;
  logic [31:0]   bp_addr = '0;
  logic          bp_valid = 1'b0;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // Model state
  bit m_hist[$];
  bit m_acc, m_press, m_cpu_en, m_latch;
  int m_state, m_count, m_age;

  mips_step_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .RUN_DIV(DIV),
    .CNT_W(CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .step_n      (step_n),
    .run_sw      (run_sw),
    .halt        (halt),
`ifdef MIPS_BREAK_EN
    .pc          (pc),
    .bp_addr     (bp_addr),
    .bp_valid    (bp_valid),
`endif
    .cpu_en      (cpu_en),
    .latch       (latch),
    .cycle_count (cycle_count),
    .state       (state)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input longint unsigned got,
                          input longint unsigned exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Synchronized key level seen just before edge e (edges counted from reset).
  function automatic bit sync_at(int e);
    if (e < 2) return 1'b1;
    return m_hist[e-2];
  endfunction

  // A level is accepted once DB consecutive synchronized samples differ.
  function automatic bit window_diff(int k);
    for (int j = 0; j < int'(DB); j++)
      if (sync_at(k - j) == m_acc) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_hist.delete();
    m_acc = 1'b1; m_press = 1'b0; m_cpu_en = 1'b0; m_latch = 1'b0;
    m_state = 0; m_count = 0; m_age = 0;
  endtask

  task automatic compare_all();
    check_eq("cpu_en", 64'(cpu_en), 64'(m_cpu_en));
    check_eq("latch", 64'(latch), 64'(m_latch));
    check_eq("cycle_count", 64'(cycle_count), 64'(m_count));
    check_eq("state", 64'(state), 64'(m_state));
  endtask

  task automatic tick();
    bit pulse, new_press, bp, stop;
    int ns, k;
    @(posedge clock);
    m_hist.push_back(step_n);
    k = m_hist.size() - 1;
    new_press = 1'b0;
    if (window_diff(k)) begin
      m_acc = ~m_acc;
      new_press = ~m_acc;
    end
    bp = 1'b0;
`ifdef MIPS_BREAK_EN
    bp = m_cpu_en && bp_valid && (pc == bp_addr);
`endif
    stop  = halt || bp;
    pulse = 1'b0;
    ns    = m_state;
    case (m_state)
      0: if (halt) ns = 3;
         else if (run_sw) begin ns = 2; m_age = 0; end
         else if (m_press) begin ns = 1; pulse = 1'b1; end
      1: ns = stop ? 3 : 0;
      2: if (stop) ns = 3;
         else if (!run_sw) ns = 0;
         else begin
           m_age++;
           if (m_age % int'(DIV) == 0) pulse = 1'b1;
         end
      default: ns = 3;
    endcase
    m_count  = (m_count + int'(m_cpu_en)) % (1 << CW);
    m_latch  = m_cpu_en;
    m_cpu_en = pulse;
    m_state  = ns;
    m_press  = new_press;
    #1;
    compare_all();
  endtask

  // Assert reset between edges and check that it clears outputs at once.
  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("rst_cpu_en", 64'(cpu_en), 0);
    check_eq("rst_latch", 64'(latch), 0);
    check_eq("rst_count", 64'(cycle_count), 0);
    check_eq("rst_state", 64'(state), 0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int en_cyc, lat_cyc, pulses, last, gap_bad, cnt0;

    // Reset with arbitrary inputs, then release with quiet inputs.
    step_n = 1'($urandom); run_sw = 1'($urandom); halt = 1'($urandom);
    #2;
    apply_reset();
    step_n = 1'b1; run_sw = 1'b0; halt = 1'b0;
    repeat (3) tick();
    check_eq("idle_after_reset", 64'(state), 0);

    // Clean step: pulse at cycle 7, latch at cycle 8.
    apply_reset();
    en_cyc = -1; lat_cyc = -1;
    step_n = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (cpu_en && en_cyc < 0) en_cyc = c;
      if (latch && lat_cyc < 0) lat_cyc = c;
    end
    step_n = 1'b1;
    repeat (10) tick();
    check_eq("step_en_cycle", 64'(en_cyc), 7);
    check_eq("step_latch_cycle", 64'(lat_cyc), 8);
    check_eq("step_count", 64'(cycle_count), 1);

    // Bounce: toggling every 2 cycles never qualifies.
    apply_reset();
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (c % 2 == 0) step_n = ~step_n;
      tick();
      pulses += int'(cpu_en);
    end
    step_n = 1'b1;
    repeat (10) begin tick(); pulses += int'(cpu_en); end
    check_eq("bounce_pulses", 64'(pulses), 0);
    check_eq("bounce_count", 64'(cycle_count), 0);

    // Run: 27 cycles give 5 pulses, 5 apart; leaving RUN stops pulses.
    apply_reset();
    pulses = 0; last = -1; gap_bad = 0;
    run_sw = 1'b1;
    for (int c = 1; c <= 27; c++) begin
      tick();
      if (cpu_en) begin
        if (last >= 0 && c - last != int'(DIV)) gap_bad++;
        last = c;
        pulses++;
      end
    end
    run_sw = 1'b0;
    tick();
    check_eq("run_exit_state", 64'(state), 0);
    repeat (10) begin tick(); pulses += int'(cpu_en); end
    check_eq("run_pulses", 64'(pulses), 5);
    check_eq("run_gap_errors", 64'(gap_bad), 0);
    check_eq("run_count", 64'(cycle_count), 5);

    // Halt on the cycle a RUN pulse is due: pulse suppressed, sticky HALTED.
    apply_reset();
    run_sw = 1'b1;
    repeat (5) tick();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check_eq("halt_suppress", 64'(cpu_en), 0);
    check_eq("halt_state", 64'(state), 3);
    cnt0 = int'(cycle_count);
    for (int c = 0; c < 30; c++) begin
      if (c % 7 == 0) run_sw = ~run_sw;
      step_n = (c >= 10 && c < 20) ? 1'b0 : 1'b1;
      tick();
    end
    check_eq("halt_sticky", 64'(state), 3);
    check_eq("halt_count", 64'(cycle_count), 64'(cnt0));
    run_sw = 1'b0; step_n = 1'b1;

`ifdef MIPS_BREAK_EN
    // Breakpoint at 0x0C: that pulse is issued, then HALTED.
    apply_reset();
    bp_addr = 32'h0C; bp_valid = 1'b1; pc = '0;
    run_sw = 1'b1;
    for (int c = 0; c < 60 && m_state != 3; c++) begin
      tick();
      if (m_latch) pc = pc + 32'd4;
    end
    tick();
    check_eq("bp_state", 64'(state), 3);
    check_eq("bp_count", 64'(cycle_count), 4);
    bp_valid = 1'b0; run_sw = 1'b0; pc = '0;
`endif

    // Random stimulus including mid-operation resets.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) step_n = ~step_n;
      if ($urandom_range(0, 40) == 0) run_sw = ~run_sw;
      halt = ($urandom_range(0, 500) == 0);
      if ($urandom_range(0, 300) == 0) apply_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
